result_demux_1to2: RTL and testbench

- Registered 1-to-2 result router: the inverse of the 2-to-1 ALU operand/result selector.
- Takes one stream of results with a per-word select bit and steers each word to one of two destination channels.
- Each channel has a small per-channel FIFO and a valid/ready handshake.
- Sits between the ALU result mux and two consumers (e.g. register writeback and store/branch path), decoupling their stalls from each other.

---
 rtl/result_demux_1to2.sv | 149 ++++++++++++++
 tb/tb_result_demux_1to2.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/result_demux_1to2.sv
// Registered 1-to-2 result router: steers each input word to one of two
// per-channel FIFOs by In_sel. Optional statistics counters: DEMUX_STATS_EN.

module result_demux_1to2_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_pop;

  assign w_pop = !r_empty && i_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (!i_push && w_pop)
      w_count_nxt = r_count - 1'b1;
  end

  // Control state: pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage carries no reset; stale contents are masked by the empty flag
  always_ff @(posedge clk) begin
    if (i_push)
      r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = !r_empty;
  assign o_data  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = r_full;
endmodule

module result_demux_1to2 #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In_data,
  input  logic             In_sel,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Out0_data,
  output logic             Out0_valid,
  input  logic             Out0_ready,
  output logic [WIDTH-1:0] Out1_data,
  output logic             Out1_valid,
  input  logic             Out1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] Cnt0,
  output logic [CNT_W-1:0] Cnt1
`endif
);
  logic w_full0;
  logic w_full1;
  logic w_push0;
  logic w_push1;

  // Acceptance depends only on the selected channel's registered full flag,
  // so a stalled channel never blocks words headed for the other one.
  assign In_ready = In_sel ? !w_full1 : !w_full0;
  assign w_push0  = In_valid && In_ready && !In_sel;
  assign w_push1  = In_valid && In_ready &&  In_sel;

  result_demux_1to2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch0 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push0),
    .i_data  (In_data),
    .i_ready (Out0_ready),
    .o_valid (Out0_valid),
    .o_data  (Out0_data),
    .o_full  (w_full0)
  );

  result_demux_1to2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push1),
    .i_data  (In_data),
    .i_ready (Out1_ready),
    .o_valid (Out1_valid),
    .o_data  (Out1_data),
    .o_full  (w_full1)
  );

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Per-channel accept counters, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push0)
        r_cnt0 <= sat_inc(r_cnt0);
      if (w_push1)
        r_cnt1 <= sat_inc(r_cnt1);
    end
  end

  assign Cnt0 = r_cnt0;
  assign Cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_result_demux_1to2.sv
// Randomized self-checking bench for result_demux_1to2 against a queue model;
// counter checks are compiled in when DEMUX_STATS_EN is defined.

module tb_result_demux_1to2;
  localparam int W  = 6;
  localparam int D  = 2;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] In_data;
  logic         In_sel;
  logic         In_valid;
  logic         In_ready;
  logic [W-1:0] Out0_data;
  logic         Out0_valid;
  logic         Out0_ready;
  logic [W-1:0] Out1_data;
  logic         Out1_valid;
  logic         Out1_ready;
`ifdef DEMUX_STATS_EN
  logic [CW-1:0] Cnt0;
  logic [CW-1:0] Cnt1;
`endif

  always #5 clk = ~clk;

  result_demux_1to2 #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .In_data    (In_data),
    .In_sel     (In_sel),
    .In_valid   (In_valid),
    .In_ready   (In_ready),
    .Out0_data  (Out0_data),
    .Out0_valid (Out0_valid),
    .Out0_ready (Out0_ready),
    .Out1_data  (Out1_data),
    .Out1_valid (Out1_valid),
    .Out1_ready (Out1_ready)
`ifdef DEMUX_STATS_EN
    ,
    .Cnt0       (Cnt0),
    .Cnt1       (Cnt1)
`endif
  );

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int m_cnt0;
  int m_cnt1;
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check outputs at negedge, advance model at posedge
  task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                      input logic r0, input logic r1, input logic rs);
    bit acc, p0, p1;
    int sat;
    In_valid   = v;
    In_sel     = s;
    In_data    = d;
    Out0_ready = r0;
    Out1_ready = r1;
    rst        = rs;
    @(negedge clk);
    chk("out0_valid", Out0_valid, q0.size() != 0);
    chk("out0_data",  Out0_data,  (q0.size() != 0) ? q0[0] : '0);
    chk("out1_valid", Out1_valid, q1.size() != 0);
    chk("out1_data",  Out1_data,  (q1.size() != 0) ? q1[0] : '0);
    chk("in_ready",   In_ready,   s ? (q1.size() < D) : (q0.size() < D));
`ifdef DEMUX_STATS_EN
    chk("cnt0", Cnt0, m_cnt0);
    chk("cnt1", Cnt1, m_cnt1);
`endif
    acc = v && (s ? (q1.size() < D) : (q0.size() < D));
    p0  = r0 && (q0.size() != 0);
    p1  = r1 && (q1.size() != 0);
    sat = (1 << CW) - 1;
    @(posedge clk);
    if (rs) begin
      q0.delete();
      q1.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc && !s) begin
        q0.push_back(d);
        if (m_cnt0 < sat) m_cnt0++;
      end
      if (acc && s) begin
        q1.push_back(d);
        if (m_cnt1 < sat) m_cnt1++;
      end
    end
    #1;
  endtask

  initial begin
    m_cnt0 = 0;
    m_cnt1 = 0;
    In_valid = 0; In_sel = 0; In_data = '0;
    Out0_ready = 0; Out1_ready = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;

    // Reset then idle, In_ready for both selects
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Single words to each channel, both consumers ready
    step(1, 0, 6'd0, 1, 1, 0);
    step(1, 1, 6'd1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // Channel 0 stalled: fills, blocks 7, channel 1 still flows
    step(1, 0, 6'd5, 0, 1, 0);
    step(1, 0, 6'd6, 0, 1, 0);
    step(1, 0, 6'd7, 0, 1, 0);
    step(1, 1, 6'd9, 0, 1, 0);
    step(1, 0, 6'd7, 0, 1, 0);
    step(1, 0, 6'd7, 1, 1, 0);
    step(1, 0, 6'd7, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // Simultaneous push and pop on a one-word channel
    step(1, 0, 6'd8, 0, 0, 0);
    step(1, 0, 6'd3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Reset mid-stream discards a full channel 1
    step(1, 1, 6'd10, 0, 0, 0);
    step(1, 1, 6'd11, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 1, 1, 0);
    step(1, 1, 6'd12, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // Counter saturation: five words to channel 0, one to channel 1
    step(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, W'(i + 20), 1, 1, 0);
    step(1, 1, 6'd33, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, W'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
